systolic_skew_feeder: RTL

Upstream stage of the 2x2 systolic multiplier. Holds two 2x2 operand matrices A and B loaded over a simple write port. On a `go` pulse it clears the array, then drives the diagonally skewed west (A rows) and north (B columns) operand streams with matching control strobes. It then waits for the array's done flag and reports completion, so firmware issues a single command instead of hand-sequencing every cycle.

---
 rtl/systolic_skew_feeder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/systolic_skew_feeder.sv
// Operand skew feeder for the 2x2 systolic multiplier.
// Holds matrices A and B, and on a go pulse runs:
//   CLEAR -> FEED (3 steps) -> DRAIN (2 steps) -> WAIT
// It drives the diagonally skewed west and north operand streams,
// then waits for the array's done flag.
// Every output is registered from the next-state decode, so each output
// lines up with the state entered on the same edge.
module systolic_skew_feeder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [2:0]       load_sel,
  input  logic [WIDTH-1:0] load_data,
  input  logic             go,
  input  logic             arr_done,
  output logic             arr_reset,
  output logic             arr_start,
  output logic             arr_shift,
  output logic [WIDTH-1:0] west0,
  output logic [WIDTH-1:0] west1,
  output logic [WIDTH-1:0] north0,
  output logic [WIDTH-1:0] north1,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [1:0]       t_q, t_d;
  // Element order: A00, A01, A10, A11, B00, B01, B10, B11
  logic [WIDTH-1:0] mat_q [8];

  logic             arr_reset_q, arr_reset_d;
  logic             arr_start_q, arr_start_d;
  logic             arr_shift_q, arr_shift_d;
  logic [WIDTH-1:0] west0_q, west0_d, west1_q, west1_d;
  logic [WIDTH-1:0] north0_q, north0_d, north1_q, north1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Sequencer next state; t counts steps within FEED and DRAIN
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      S_IDLE: if (go) state_d = S_CLEAR;
      S_CLEAR: begin
        state_d = S_FEED;
        t_d     = 2'd0;
      end
      S_FEED: begin
        if (t_q == 2'd2) begin
          state_d = S_DRAIN;
          t_d     = 2'd0;
        end else begin
          t_d = t_q + 2'd1;
        end
      end
      S_DRAIN: begin
        if (t_q == 2'd1) state_d = S_WAIT;
        else             t_d     = t_q + 2'd1;
      end
      S_WAIT: if (arr_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the state about to be entered (outputs are registered)
  always_comb begin
    arr_reset_d = 1'b0;
    arr_start_d = 1'b0;
    arr_shift_d = 1'b0;
    west0_d     = '0;
    west1_d     = '0;
    north0_d    = '0;
    north1_d    = '0;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_q == S_WAIT) && arr_done;
    case (state_d)
      S_CLEAR: arr_reset_d = 1'b1;
      S_FEED: begin
        arr_start_d = 1'b1;
        arr_shift_d = 1'b1;
        case (t_d)
          2'd0: begin
            west0_d  = mat_q[0];
            north0_d = mat_q[4];
          end
          2'd1: begin
            west0_d  = mat_q[1];
            west1_d  = mat_q[2];
            north0_d = mat_q[6];
            north1_d = mat_q[5];
          end
          default: begin
            west1_d  = mat_q[3];
            north1_d = mat_q[7];
          end
        endcase
      end
      S_DRAIN: begin
        arr_start_d = 1'b1;
        arr_shift_d = 1'b1;
      end
      S_WAIT: arr_start_d = 1'b1;
      default: ;
    endcase
  end

  // State, step counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      t_q         <= 2'd0;
      arr_reset_q <= 1'b0;
      arr_start_q <= 1'b0;
      arr_shift_q <= 1'b0;
      west0_q     <= '0;
      west1_q     <= '0;
      north0_q    <= '0;
      north1_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      arr_reset_q <= arr_reset_d;
      arr_start_q <= arr_start_d;
      arr_shift_q <= arr_shift_d;
      west0_q     <= west0_d;
      west1_q     <= west1_d;
      north0_q    <= north0_d;
      north1_q    <= north1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Matrix storage: writable only in IDLE, frozen while a sequence runs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mat_q[i] <= '0;
    end else if (state_q == S_IDLE && load_en) begin
      mat_q[load_sel] <= load_data;
    end
  end

  assign arr_reset = arr_reset_q;
  assign arr_start = arr_start_q;
  assign arr_shift = arr_shift_q;
  assign west0     = west0_q;
  assign west1     = west1_q;
  assign north0    = north0_q;
  assign north1    = north1_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
